// File: rtl/uart_tx_fifo_if.sv
// Purpose : bundle of the byte-write, divisor-load and status/serial signals of uart_tx_fifo.
// Latency : n/a (wires only).
// Backpressure: producer must watch full; writes while full are dropped and flagged by overflow.
// Ports   : wdata/we (byte write), div/div_we (divisor load), full/empty/count/overflow (FIFO status),
//           busy/tx (transmitter). master = producer side, slave = uart_tx_fifo.
interface uart_tx_fifo_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]    wdata;
    logic          we;
    logic [15:0]   div;
    logic          div_we;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          busy;
    logic          tx;

    modport master (
        output wdata, we, div, div_we,
        input  full, empty, count, overflow, busy, tx
    );

    modport slave (
        input  wdata, we, div, div_we,
        output full, empty, count, overflow, busy, tx
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Purpose : byte FIFO feeding an 8N1 UART transmitter with a programmable bit period.
// Latency : byte written into an empty FIFO at edge N while idle -> start bit driven at edge N+1.
// Backpressure: full when DEPTH entries held; a write while full is dropped with a one-cycle overflow pulse.
// Ports   : clk (rising edge), rst (async active-high), bus (uart_tx_fifo_if.slave):
//           wdata/we byte write, div/div_we divisor load, full/empty/count/overflow status,
//           busy (frame in progress), tx (registered serial line, idle high).
module uart_tx_fifo #(
    parameter int          DEPTH       = 8,
    parameter logic [15:0] DIV_DEFAULT = 16'd868
) (
    input  logic clk,
    input  logic rst,
    uart_tx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] occ;
    logic [15:0]   divisor;
    logic [15:0]   period;
    logic [15:0]   bit_cnt;
    logic [7:0]    shreg;
    logic [2:0]    bit_idx;
    logic          tx_q;
    logic          busy_q;
    logic          ovf_q;

    logic          full_w;
    logic          empty_w;
    logic          push;
    logic          pop;
    logic          bit_end;
    logic [15:0]   next_period;

    // Status is decoded from the registered occupancy only.
    assign full_w      = (occ == CW'(DEPTH));
    assign empty_w     = (occ == '0);
    assign bit_end     = (bit_cnt == 16'd0);
    // Bit periods shorter than 2 clocks are clamped to 2.
    assign next_period = (divisor < 16'd2) ? 16'd2 : divisor;

    // full is the pre-pop value, so a write while full is dropped even if a pop happens on the same edge.
    assign push = bus.we && !full_w;
    assign pop  = !empty_w && ((state == IDLE) || (state == STOP && bit_end));

    assign bus.full     = full_w;
    assign bus.empty    = empty_w;
    assign bus.count    = occ;
    assign bus.overflow = ovf_q;
    assign bus.busy     = busy_q;
    assign bus.tx       = tx_q;

    // Storage carries no reset; discarding contents is done by resetting the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            ovf_q   <= 1'b0;
            divisor <= DIV_DEFAULT;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
            ovf_q <= bus.we && full_w;
            if (bus.div_we) begin
                divisor <= bus.div;
            end
        end
    end

    // Transmit FSM. The bit counter is loaded with period-1 at every bit boundary and the
    // boundary fires when it reaches zero, giving exactly 'period' clocks per bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            period  <= 16'd2;
            bit_cnt <= 16'd0;
            shreg   <= 8'd0;
            bit_idx <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg   <= mem[rd_ptr];
                        period  <= next_period;
                        bit_cnt <= next_period - 16'd1;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx_q    <= shreg[0];
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_idx <= 3'd0;
                        bit_cnt <= period - 16'd1;
                        state   <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        bit_cnt <= period - 16'd1;
                        if (bit_idx == 3'd7) begin
                            tx_q  <= 1'b1;
                            state <= STOP;
                        end else begin
                            tx_q    <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            // Back-to-back frame: start bit follows the stop bit with no idle gap.
                            shreg   <= mem[rd_ptr];
                            period  <= next_period;
                            bit_cnt <= next_period - 16'd1;
                            tx_q    <= 1'b0;
                            state   <= START;
                        end else begin
                            tx_q   <= 1'b1;
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                default: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule
